// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: registers the evaluated branch, checks it against the front-end
// prediction, strobes a predictor update and sequences redirect/flush toward fetch.
module branch_resolve_unit #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_sel_i,
  input  logic             in_cond_i,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic [XLEN-1:0]  in_imm_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_target_i,
  output logic             redirect_valid_o,
  input  logic             redirect_ready_i,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             upd_valid_o,
  output logic [XLEN-1:0]  upd_pc_o,
  output logic             upd_taken_o,
  output logic [XLEN-1:0]  upd_target_o,
  output logic             illegal_sel_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  // state    | meaning
  // IDLE     | ready for a new branch
  // REDIRECT | presenting corrected PC to fetch, younger work flushed
  // FLUSH    | redirect accepted, flush held for FLUSH_CYCLES cycles
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [1:0]       state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [XLEN-1:0]  rpc_q, rpc_d;
  logic             upd_valid_q, upd_valid_d;
  logic [XLEN-1:0]  upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic [XLEN-1:0]  upd_target_q, upd_target_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic            legal;
  logic            mispred;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fallthru;

  assign legal    = (in_sel_i <= 3'd5);
  assign target   = in_pc_i + in_imm_i;
  assign fallthru = in_pc_i + XLEN'(4);
  assign mispred  = (in_cond_i != pred_taken_i) ||
                    (in_cond_i && pred_taken_i && (pred_target_i != target));

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    rpc_d        = rpc_q;
    upd_valid_d  = 1'b0;
    upd_pc_d     = upd_pc_q;
    upd_taken_d  = upd_taken_q;
    upd_target_d = upd_target_q;
    illegal_d    = 1'b0;
    bcnt_d       = bcnt_q;
    mcnt_d       = mcnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (legal) begin
            upd_valid_d  = 1'b1;
            upd_pc_d     = in_pc_i;
            upd_taken_d  = in_cond_i;
            upd_target_d = target;
            if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_W'(1);
            if (mispred) begin
              if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
              rpc_d   = in_cond_i ? target : fallthru;
              state_d = REDIRECT;
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fcnt_q       <= '0;
      rpc_q        <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
      illegal_q    <= 1'b0;
      bcnt_q       <= '0;
      mcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      rpc_q        <= rpc_d;
      upd_valid_q  <= upd_valid_d;
      upd_pc_q     <= upd_pc_d;
      upd_taken_q  <= upd_taken_d;
      upd_target_q <= upd_target_d;
      illegal_q    <= illegal_d;
      bcnt_q       <= bcnt_d;
      mcnt_q       <= mcnt_d;
    end
  end

  assign in_ready_o       = (state_q == IDLE);
  assign redirect_valid_o = (state_q == REDIRECT);
  assign flush_o          = (state_q == REDIRECT) || (state_q == FLUSH);
  assign redirect_pc_o    = rpc_q;
  assign upd_valid_o      = upd_valid_q;
  assign upd_pc_o         = upd_pc_q;
  assign upd_taken_o      = upd_taken_q;
  assign upd_target_o     = upd_target_q;
  assign illegal_sel_o    = illegal_q;
  assign branch_cnt_o     = bcnt_q;
  assign mispred_cnt_o    = mcnt_q;

endmodule
